// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle control unit:
//   - FSM state encoding (4-bit)
//   - ALUControl opcodes
//   - AdrSrc / ALUSrcB / ResultSrc select codes
//   - OP / type / cond field codes
//   - decode_exec(): maps OP/type of a data-processing or shift
//     instruction to its ALU opcode, and flags reserved codes and CMP.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_ALU_WB  = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_CLR = 4'b0101;
    localparam logic [3:0] ALU_ROL = 4'b0110;
    localparam logic [3:0] ALU_ROR = 4'b0111;
    localparam logic [3:0] ALU_LSL = 4'b1000;
    localparam logic [3:0] ALU_LSR = 4'b1001;
    localparam logic [3:0] ALU_ASR = 4'b1010;

    // Datapath mux selects
    localparam logic [1:0] ADR_PC     = 2'b00;
    localparam logic [1:0] ADR_RESULT = 2'b01;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction class (instr[15:14])
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_MEM   = 2'b10;
    localparam logic [1:0] OP_BR    = 2'b11;

    // Data-processing sub-ops
    localparam logic [2:0] DP_ADD = 3'b000;
    localparam logic [2:0] DP_SUB = 3'b001;
    localparam logic [2:0] DP_OR  = 3'b010;
    localparam logic [2:0] DP_XOR = 3'b011;
    localparam logic [2:0] DP_AND = 3'b100;
    localparam logic [2:0] DP_CLR = 3'b101;
    localparam logic [2:0] DP_CMP = 3'b110;

    // Shift sub-ops
    localparam logic [2:0] SH_ROL = 3'b000;
    localparam logic [2:0] SH_ROR = 3'b001;
    localparam logic [2:0] SH_LSL = 3'b010;
    localparam logic [2:0] SH_ASR = 3'b011;
    localparam logic [2:0] SH_LSR = 3'b100;

    // Branch sub-ops
    localparam logic [2:0] BR_B    = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BL   = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b011;
    localparam logic [2:0] BR_HALT = 3'b111;

    // Condition codes (instr[1:0])
    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_EQ = 2'b01;
    localparam logic [1:0] COND_NE = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;

    typedef struct packed {
        logic       valid;  // 0 for reserved type codes (executed as NOP)
        logic       cmp;    // flag-only op, no write-back
        logic [3:0] alu;
    } exec_dec_t;

    function automatic exec_dec_t decode_exec(input logic [1:0] op, input logic [2:0] t);
        exec_dec_t d;
        d.valid = 1'b1;
        d.cmp   = 1'b0;
        d.alu   = ALU_ADD;
        if (op == OP_DP) begin
            case (t)
                DP_ADD:  d.alu = ALU_ADD;
                DP_SUB:  d.alu = ALU_SUB;
                DP_OR:   d.alu = ALU_OR;
                DP_XOR:  d.alu = ALU_XOR;
                DP_AND:  d.alu = ALU_AND;
                DP_CLR:  d.alu = ALU_CLR;
                DP_CMP:  begin d.alu = ALU_SUB; d.cmp = 1'b1; end
                default: d.valid = 1'b0;
            endcase
        end else begin
            case (t)
                SH_ROL:  d.alu = ALU_ROL;
                SH_ROR:  d.alu = ALU_ROR;
                SH_LSL:  d.alu = ALU_LSL;
                SH_ASR:  d.alu = ALU_ASR;
                SH_LSR:  d.alu = ALU_LSR;
                default: d.valid = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/mc_cond_check.sv
// mc_cond_check
//   Holds the NZCV flag register and evaluates conditions against it.
//   Ports:
//     clk, rst    clock / synchronous active-high reset (flags cleared)
//     flag_we     capture alu_flags at the end of this cycle
//     alu_flags   {N,Z,C,V} live from the ALU
//     cond        instr[1:0] condition for data-processing / shift ops
//     br_type     instr[13:11] branch sub-op
//     pass        condition satisfied by stored flags (always 1 if COND_EN=0)
//     taken       branch taken according to stored flags
module mc_cond_check
    import mc_ctrl_pkg::*;
#(
    parameter bit COND_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_we,
    input  logic [3:0] alu_flags,
    input  logic [1:0] cond,
    input  logic [2:0] br_type,
    output logic       pass,
    output logic       taken
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       flag_n;
    logic       flag_z;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];

    // C and V are stored for completeness but no condition tests them yet.
    logic unused_cv;
    assign unused_cv = ^flags_q[1:0];

    always_comb begin
        flags_d = flag_we ? alu_flags : flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        pass = 1'b1;
        if (COND_EN) begin
            case (cond)
                COND_AL: pass = 1'b1;
                COND_EQ: pass = flag_z;
                COND_NE: pass = ~flag_z;
                COND_MI: pass = flag_n;
                default: pass = 1'b1;
            endcase
        end
    end

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_B, BR_BL: taken = 1'b1;
            BR_BNE:      taken = ~flag_z;
            BR_BEQ:      taken = flag_z;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit
//   Moore FSM sequencing the 8-bit multi-cycle datapath (shared memory,
//   8x8 register file, R6 = PC). One control word per cycle.
//   Inputs : clk, rst (sync, active high), OP, instr_type, cond, Rd, ALU_flags
//   Outputs: PCWrite, MemWrite, IRWrite, ImmSrc, RegWrite, ALUSrcA, AdrSrc,
//            ALUControl, ALUSrcB, RegSrc, ResultSrc, halted
//   instr_type carries instr[13:11]; "type" is a reserved word and cannot
//   be used as a port name.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter bit COND_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] OP,
    input  logic [2:0] instr_type,
    input  logic [1:0] cond,
    input  logic [2:0] Rd,
    input  logic [3:0] ALU_flags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ImmSrc,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] AdrSrc,
    output logic [3:0] ALUControl,
    output logic [1:0] ALUSrcB,
    output logic [2:0] RegSrc,
    output logic [1:0] ResultSrc,
    output logic       halted
);

    state_t    state_q;
    state_t    state_d;
    exec_dec_t exec_dec;
    logic      pass;
    logic      taken;
    logic      flag_we;

    // The destination index reaches the register file straight from the IR.
    logic unused_rd;
    assign unused_rd = ^Rd;

    assign exec_dec = decode_exec(OP, instr_type);
    // Reserved codes never touch the flags; skipped ops leave them alone too.
    assign flag_we  = (state_q == S_EXEC_R) && exec_dec.valid && pass;

    mc_cond_check #(.COND_EN(COND_EN)) u_cond (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (flag_we),
        .alu_flags (ALU_flags),
        .cond      (cond),
        .br_type   (instr_type),
        .pass      (pass),
        .taken     (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ImmSrc     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        AdrSrc     = ADR_PC;
        ALUControl = ALU_ADD;
        ALUSrcB    = SRCB_REG;
        RegSrc     = 3'b000;
        ResultSrc  = RES_ALUOUT;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                AdrSrc    = ADR_PC;
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // PC+4 computed again so R6 reads as PC+8 during operand fetch.
                RegSrc[2] = (OP != OP_BR);
                RegSrc[1] = (OP == OP_MEM) && instr_type[0];
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                case (OP)
                    OP_DP, OP_SHIFT: state_d = S_EXEC_R;
                    OP_MEM:          state_d = S_MEM_ADR;
                    default:         state_d = (instr_type == BR_HALT) ? S_HALT : S_BRANCH;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b0;
                ALUSrcB    = SRCB_REG;
                ALUControl = exec_dec.alu;
                state_d    = (exec_dec.valid && pass && !exec_dec.cmp) ? S_ALU_WB : S_FETCH;
            end
            S_ALU_WB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADR: begin
                ALUSrcA = 1'b0;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = 1'b0;
                state_d = instr_type[0] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                AdrSrc    = ADR_RESULT;
                ResultSrc = RES_ALUOUT;
                state_d   = S_MEM_WB;
            end
            S_MEM_WB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_WR: begin
                AdrSrc    = ADR_RESULT;
                ResultSrc = RES_ALUOUT;
                MemWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b0;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = 1'b1;
                ResultSrc = RES_ALU;
                PCWrite   = taken;
                if (instr_type == BR_BL) begin
                    RegWrite  = 1'b1;
                    RegSrc[0] = 1'b1;
                end
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase

        // The PC register lets its write enable beat reset, so every write
        // strobe has to be killed here while rst is high.
        if (rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            halted   = 1'b0;
        end
    end

endmodule
